// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHK     = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam int INSTR_W   = 16;
  localparam int ADDR_STEP = 2;

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Pairs a high and a low stream byte into one big-endian instruction word.
// Latency: word_valid pulses one cycle after the low byte loads; no backpressure, the caller gates loads.
module byte_pair_assembler
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               hi_load,
  input  logic               lo_load,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q       <= 8'h00;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= lo_load & ~clear;
      if (clear) begin
        hi_q <= 8'h00;
      end else if (hi_load) begin
        hi_q <= byte_in;
      end
      if (lo_load && !clear) begin
        word <= {hi_q, byte_in};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the CPU until done.
// Latency: write strobe and done one cycle after the closing byte; in_ready drops only in DONE/ERR. Option: CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [INSTR_W-1:0]    wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

`ifdef CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
  logic [7:0] csum_q;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t      state, state_nxt;
  logic        accept;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [15:0] len_now;
  logic [15:0] word_cnt;
  logic        last_word;

  // reload wins over a byte offered on the same edge
  assign accept    = in_valid & in_ready & ~reload;
  assign len_now   = {len_hi_q, in_data};
  // counter has already absorbed every earlier word's strobe when DATA_LO is accepted
  assign last_word = (word_cnt + 16'd1) == len_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LEN_HI;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (reload) begin
      state_nxt = LEN_HI;
    end else if (accept) begin
      case (state)
        LEN_HI:  state_nxt = LEN_LO;
        LEN_LO: begin
          if (len_now > 16'(MAX_WORDS)) state_nxt = ERR;
          else if (len_now == 16'd0)    state_nxt = AFTER_DATA;
          else                          state_nxt = DATA_HI;
        end
        DATA_HI: state_nxt = DATA_LO;
        DATA_LO: state_nxt = last_word ? AFTER_DATA : DATA_HI;
`ifdef CHECKSUM_EN
        CHK:     state_nxt = (in_data == csum_q) ? DONE : ERR;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      DONE: begin
        in_ready = 1'b0;
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR: begin
        in_ready = 1'b0;
        error    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi_q <= 8'h00;
      len_q    <= 16'd0;
      word_cnt <= 16'd0;
      wr_addr  <= BASE_ADDR;
    end else begin
      if (accept && state == LEN_HI) len_hi_q <= in_data;
      if (accept && state == LEN_LO) len_q    <= len_now;
      if (reload) begin
        word_cnt <= 16'd0;
        wr_addr  <= BASE_ADDR;
      end else if (wr_en) begin
        word_cnt <= word_cnt + 16'd1;
        wr_addr  <= wr_addr + ADDR_WIDTH'(ADDR_STEP);
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else if (reload || state == LEN_HI) begin
      csum_q <= 8'h00;
    end else if (accept && (state == DATA_HI || state == DATA_LO)) begin
      csum_q <= csum_q ^ in_data;
    end
  end
`endif

  byte_pair_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (reload),
    .hi_load    (accept && state == DATA_HI),
    .lo_load    (accept && state == DATA_LO),
    .byte_in    (in_data),
    .word       (wr_data),
    .word_valid (wr_en)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go to a scoreboard queue checked by a monitor.
module tb_imem_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .reload   (reload),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(exp_q.size()), 32'd1);
      else check("write", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit sent = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!sent && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        sent = 1'b1;
      end
      n++;
    end
    in_valid = 1'b0;
    if (!sent) check("accept_timeout", 32'(sent), 32'd1);
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_seq(input byte_q_t bs, input bit gap);
    foreach (bs[i]) send_byte(bs[i], gap);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_ready", {31'd0, in_ready}, 32'd1);
    check("reload_flags", {29'd0, done, error, cpu_hold}, 32'b001);
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    #23;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wr", {15'd0, wr_en, wr_addr}, 32'h0000_0000);
    check("rst_data", {16'd0, wr_data}, 32'd0);
    check("rst_flags", {29'd0, done, error, cpu_hold}, 32'b001);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // two words, back to back
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0002, 16'hABCD});
    send_seq('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1'b0);
    check("s1_done", {30'd0, done, cpu_hold}, 32'b10);
    check("s1_ready", {31'd0, in_ready}, 32'd0);
    drain("s1_drain");
    check("s1_ready_after", {31'd0, in_ready}, 32'd0);
    do_reload();

    // oversize header
    send_seq('{8'h01, 8'h01}, 1'b0);
    check("s2_err", {29'd0, done, error, cpu_hold}, 32'b011);
    drain("s2_drain");
    check("s2_hold", {30'd0, error, cpu_hold}, 32'b11);
    do_reload();

    // same image, valid toggling
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0002, 16'hABCD});
    send_seq('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1'b1);
    check("s3_done", {30'd0, done, cpu_hold}, 32'b10);
    drain("s3_drain");
    do_reload();

    // reload mid-word discards the partial word
    send_seq('{8'h00, 8'h03, 8'h12}, 1'b0);
    do_reload();
    exp_q.push_back({16'h0000, 16'hBEEF});
`ifdef CHECKSUM_EN
    send_seq('{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51}, 1'b0);
`else
    send_seq('{8'h00, 8'h01, 8'hBE, 8'hEF}, 1'b0);
`endif
    check("s4_done", {30'd0, done, cpu_hold}, 32'b10);
    drain("s4_drain");
    do_reload();

    // zero-length image
`ifdef CHECKSUM_EN
    send_seq('{8'h00, 8'h00, 8'h00}, 1'b0);
`else
    send_seq('{8'h00, 8'h00}, 1'b0);
`endif
    check("s5_done", {30'd0, done, cpu_hold}, 32'b10);
    drain("s5_drain");
    do_reload();

`ifdef CHECKSUM_EN
    exp_q.push_back({16'h0000, 16'h1234});
    send_seq('{8'h00, 8'h01, 8'h12, 8'h34, 8'h26}, 1'b0);
    check("ck_good", {29'd0, done, error, cpu_hold}, 32'b100);
    drain("ck_good_drain");
    do_reload();
    exp_q.push_back({16'h0000, 16'h1234});
    send_seq('{8'h00, 8'h01, 8'h12, 8'h34, 8'h27}, 1'b0);
    check("ck_bad", {29'd0, done, error, cpu_hold}, 32'b011);
    drain("ck_bad_drain");
    do_reload();
`endif

    // async reset while the strobe is high
    send_seq('{8'h00, 8'h02, 8'h12, 8'h34}, 1'b0);
    check("s6_strobe_pre", {31'd0, wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("s6_wr", {15'd0, wr_en, wr_addr}, 32'h0000_0000);
    check("s6_data", {16'd0, wr_data}, 32'd0);
    check("s6_flags", {28'd0, in_ready, done, error, cpu_hold}, 32'b1001);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back({16'h0000, 16'hABCD});
`ifdef CHECKSUM_EN
    send_seq('{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66}, 1'b0);
`else
    send_seq('{8'h00, 8'h01, 8'hAB, 8'hCD}, 1'b0);
`endif
    check("s6_done", {30'd0, done, cpu_hold}, 32'b10);
    drain("s6_drain");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
